// File: rtl/text_fetch_arbiter.sv
// text_fetch_arbiter: one-span-ahead glyph prefetch plus display-priority sharing of the VRAM port with the host
module text_fetch_arbiter (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [9:0]  i_draw_x,
  input  logic [9:0]  i_draw_y,
  input  logic        i_host_req,
  input  logic        i_host_we,
  input  logic [10:0] i_host_addr,
  input  logic [31:0] i_host_wdata,
  output logic        o_host_ack,
  output logic [31:0] o_host_rdata,
  output logic [10:0] o_vram_addr,
  output logic        o_vram_we,
  output logic [31:0] o_vram_wdata,
  input  logic [31:0] i_vram_rdata,
  output logic [10:0] o_font_addr,
  input  logic [7:0]  i_font_data,
  output logic        o_pix_on,
  output logic [3:0]  o_fg_idx,
  output logic [3:0]  o_bg_idx
);
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int H_TOTAL = 800;
  localparam int V_TOTAL = 525;
  localparam int WORDS_PER_ROW = 40;

  logic        w_slot, w_wrap, w_grant, w_active;
  logic [9:0]  w_line;
  logic [5:0]  w_span;
  logic [10:0] w_fetch_addr;
  logic [15:0] w_char;
  logic [7:0]  w_row;
  logic [3:0]  r_line;
  logic        r_p1, r_p2, r_p3, r_p4;
  logic [31:0] r_word, r_act_word;
  logic [7:0]  r_row0, r_row1, r_act_row0, r_act_row1;
  logic        r_ack, r_we;
  logic [10:0] r_vram_addr, r_font_addr;

  // Slot detection, fetch target, VRAM/font port muxing and host completion outputs
  always_comb begin
    w_wrap = i_draw_x == 10'(H_TOTAL - 16);
    w_slot = !i_rst && i_draw_x[3:0] == 4'd0 && (i_draw_x < 10'(H_ACTIVE - 16) || w_wrap);
    w_line = w_wrap ? (i_draw_y == 10'(V_TOTAL - 1) ? 10'd0 : i_draw_y + 10'd1) : i_draw_y;
    w_span = w_wrap ? 6'd0 : i_draw_x[9:4] + 6'd1;
    w_fetch_addr = 11'(w_line[9:4]) * 11'(WORDS_PER_ROW) + 11'(w_span);
    w_grant = !i_rst && !w_slot && i_host_req && !r_ack;
    o_vram_addr = w_slot ? w_fetch_addr : w_grant ? i_host_addr : r_vram_addr;
    o_vram_we = w_grant && i_host_we;
    o_vram_wdata = w_grant ? i_host_wdata : 32'd0;
    o_font_addr = r_p2 ? {r_word[14:8], r_line} : r_p3 ? {r_word[30:24], r_line} : r_font_addr;
    o_host_ack = r_ack;
    o_host_rdata = (r_ack && !r_we) ? i_vram_rdata : 32'd0;
  end

  // Fetch pipeline, staging, span-boundary commit and host in-flight tracking
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_p1 <= 1'b0;
      r_p2 <= 1'b0;
      r_p3 <= 1'b0;
      r_p4 <= 1'b0;
      r_line <= 4'd0;
      r_word <= 32'd0;
      r_row0 <= 8'd0;
      r_row1 <= 8'd0;
      r_act_word <= 32'd0;
      r_act_row0 <= 8'd0;
      r_act_row1 <= 8'd0;
      r_ack <= 1'b0;
      r_we <= 1'b0;
      r_vram_addr <= 11'd0;
      r_font_addr <= 11'd0;
    end else begin
      r_p1 <= w_slot;
      r_p2 <= r_p1;
      r_p3 <= r_p2;
      r_p4 <= r_p3;
      if (w_slot) r_line <= w_line[3:0];
      if (r_p1) r_word <= i_vram_rdata;
      if (r_p3) r_row0 <= i_font_data;
      if (r_p4) r_row1 <= i_font_data;
      if (i_draw_x[3:0] == 4'hf) begin
        r_act_word <= r_word;
        r_act_row0 <= r_row0;
        r_act_row1 <= r_row1;
      end
      r_ack <= w_grant;
      r_we <= o_vram_we;
      r_vram_addr <= o_vram_addr;
      r_font_addr <= o_font_addr;
    end
  end

  // Per-pixel foreground decision from the committed cell, blanked outside the visible area
  always_comb begin
    w_active = i_draw_x < 10'(H_ACTIVE) && i_draw_y < 10'(V_ACTIVE);
    w_char = i_draw_x[3] ? r_act_word[31:16] : r_act_word[15:0];
    w_row = i_draw_x[3] ? r_act_row1 : r_act_row0;
    o_pix_on = w_active && (w_row[~i_draw_x[2:0]] ^ w_char[15]);
    o_fg_idx = w_active ? w_char[7:4] : 4'd0;
    o_bg_idx = w_active ? w_char[3:0] : 4'd0;
  end
endmodule

// File: tb/tb_text_fetch_arbiter.sv
// tb_text_fetch_arbiter: randomized host traffic and directed display steps checked against a pixel-level reference
module tb_text_fetch_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [9:0]  draw_x, draw_y;
  logic        host_req, host_we, host_ack, vram_we, pix_on;
  logic [10:0] host_addr, vram_addr, font_addr;
  logic [31:0] host_wdata, host_rdata, vram_wdata, vram_rdata;
  logic [7:0]  font_data;
  logic [3:0]  fg_idx, bg_idx;

  text_fetch_arbiter dut (
    .i_clk(clk), .i_rst(rst), .i_draw_x(draw_x), .i_draw_y(draw_y),
    .i_host_req(host_req), .i_host_we(host_we), .i_host_addr(host_addr), .i_host_wdata(host_wdata),
    .o_host_ack(host_ack), .o_host_rdata(host_rdata),
    .o_vram_addr(vram_addr), .o_vram_we(vram_we), .o_vram_wdata(vram_wdata), .i_vram_rdata(vram_rdata),
    .o_font_addr(font_addr), .i_font_data(font_data),
    .o_pix_on(pix_on), .o_fg_idx(fg_idx), .o_bg_idx(bg_idx)
  );

  logic [31:0] vram [2048];
  logic [31:0] shadow [2048];
  logic [7:0]  font [2048];
  logic [31:0] snap [525][40];
  bit          snap_v [525][40];
  int          x, y, total, bad, age, lat, hold_pct, start_pct;
  bit          req, we_q, acked, auto_host, rst_q;
  logic [10:0] addr_q, c_vaddr, c_faddr;
  logic [31:0] wdata_q, c_wdata;
  logic        c_we;
  logic [7:0]  pa;
  logic [15:0] p16;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h at x=%0d y=%0d", tag, obs, want, x, y);
    end
  endtask

  function automatic bit is_slot(int px);
    return px % 16 == 0 && (px < 624 || px == 784);
  endfunction

  task automatic drive();
    rst = rst_q;
    draw_x = 10'(x);
    draw_y = 10'(y);
    host_req = req;
    host_we = we_q;
    host_addr = addr_q;
    host_wdata = wdata_q;
  endtask

  task automatic host_set(bit we, int addr, logic [31:0] data);
    req = 1;
    age = 0;
    we_q = we;
    addr_q = 11'(addr);
    wdata_q = data;
  endtask

  task automatic new_req();
    host_set(1'($urandom_range(1)), $urandom_range(1199, 8), $urandom);
  endtask

  // Reference: each fetch slot snapshots the VRAM word of its target (line, span);
  // a visible pixel then shows exactly that snapshot decoded through the font.
  task automatic sample();
    int ty, ts, a;
    logic [31:0] w;
    logic [15:0] ch;
    logic [7:0] r;
    bit grant_cyc, e_ack, ep;
    logic [3:0] efg, ebg;
    @(negedge clk);
    c_we = vram_we;
    c_vaddr = vram_addr;
    c_wdata = vram_wdata;
    c_faddr = font_addr;
    if (rst) begin
      age = 0;
      for (int i = 0; i < 525; i++) for (int j = 0; j < 40; j++) snap_v[i][j] = 0;
      return;
    end
    grant_cyc = 0;
    e_ack = 0;
    if (req) begin
      if (age == 0) lat = is_slot(x) ? 2 : 1;
      if (age == lat - 1) begin
        grant_cyc = 1;
        chk("grant_we", 32'(vram_we), 32'(we_q));
        chk("grant_addr", 32'(vram_addr), 32'(addr_q));
        if (we_q) chk("grant_wdata", vram_wdata, wdata_q);
      end
      e_ack = age == lat;
    end
    chk("host_ack", 32'(host_ack), 32'(e_ack));
    if (e_ack) begin
      chk("host_rdata", host_rdata, we_q ? 32'd0 : shadow[addr_q]);
      if (we_q) shadow[addr_q] = wdata_q;
      acked = 1;
    end
    if (req) age++;
    if (is_slot(x)) begin
      ty = x == 784 ? (y == 524 ? 0 : y + 1) : y;
      ts = x == 784 ? 0 : x / 16 + 1;
      a = (ty / 16) * 40 + ts;
      chk("slot_addr", 32'(vram_addr), 32'(a));
      chk("slot_we", 32'(vram_we), 32'd0);
      snap[ty][ts] = vram[a];
      snap_v[ty][ts] = 1;
    end else if (!grant_cyc) chk("idle_we", 32'(vram_we), 32'd0);
    ep = 0;
    efg = 0;
    ebg = 0;
    if (x < 640 && y < 480 && snap_v[y][x / 16]) begin
      w = snap[y][x / 16];
      ch = (x % 16 >= 8) ? w[31:16] : w[15:0];
      r = font[int'(ch[14:8]) * 16 + y % 16];
      ep = r[7 - x % 8] ^ ch[15];
      efg = ch[7:4];
      ebg = ch[3:0];
    end
    chk("pix_on", 32'(pix_on), 32'(ep));
    chk("fg_idx", 32'(fg_idx), 32'(efg));
    chk("bg_idx", 32'(bg_idx), 32'(ebg));
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    vram_rdata = vram[c_vaddr];
    if (c_we) vram[c_vaddr] = c_wdata;
    font_data = font[c_faddr];
    x++;
    if (x == 800) begin
      x = 0;
      y = (y == 524) ? 0 : y + 1;
    end
    if (acked) begin
      acked = 0;
      req = 0;
      if (auto_host && $urandom_range(99) < hold_pct) new_req();
    end else if (!req && auto_host && $urandom_range(99) < start_pct) new_req();
    drive();
  endtask

  task automatic run_to(int tx, int ty);
    for (int n = 0; n < 20000 && !(x == tx && y == ty); n++) begin
      sample();
      advance();
    end
  endtask

  initial begin
    total = 0; bad = 0; age = 0; lat = 1; req = 0; acked = 0; auto_host = 0;
    hold_pct = 0; start_pct = 0; we_q = 0; addr_q = 0; wdata_q = 0;
    for (int i = 0; i < 2048; i++) begin
      vram[i] = $urandom;
      font[i] = 8'($urandom);
    end
    vram[0] = 32'h4181_4181;
    font[16'h41 * 16] = 8'h18;
    for (int i = 0; i < 2048; i++) shadow[i] = vram[i];
    vram_rdata = 0;
    font_data = 0;
    rst_q = 1; x = 700; y = 524;
    drive();
    repeat (3) begin
      sample();
      advance();
    end
    rst_q = 0;
    drive();

    // Frame wrap: last line prefetches row 0 span 0
    run_to(784, 524);
    sample();
    chk("wrap_addr", 32'(vram_addr), 32'd0);
    advance();
    run_to(0, 0);

    // 'A' (code 0x41, fg 8, bg 1) on line 0, no invert
    pa = 8'h18;
    for (int i = 0; i < 8; i++) begin
      sample();
      chk("A_pix", 32'(pix_on), 32'(pa[7 - i]));
      chk("A_fg", 32'(fg_idx), 32'd8);
      chk("A_bg", 32'(bg_idx), 32'd1);
      advance();
    end

    // Host write raised on a slot cycle, then readback
    run_to(15, 0);
    sample();
    host_set(1, 5, 32'hDEAD_BEEF);
    advance();
    sample();
    advance();
    sample();
    chk("w5_we", 32'(vram_we), 32'd1);
    chk("w5_addr", 32'(vram_addr), 32'd5);
    advance();
    sample();
    chk("w5_ack", 32'(host_ack), 32'd1);
    advance();
    run_to(20, 0);
    sample();
    host_set(0, 5, 32'd0);
    advance();
    sample();
    advance();
    sample();
    chk("r5_ack", 32'(host_ack), 32'd1);
    chk("r5_data", host_rdata, 32'hDEAD_BEEF);
    advance();

    // Set invert on the left char of word 0
    run_to(39, 0);
    sample();
    host_set(1, 0, 32'h4181_C181);
    advance();

    // Reset mid-frame with a read pending, then jump to the end of the frame
    run_to(60, 0);
    sample();
    host_set(0, 7, 32'd0);
    rst_q = 1;
    advance();
    sample();
    advance();
    sample();
    chk("rst_ack", 32'(host_ack), 32'd0);
    chk("rst_rdata", host_rdata, 32'd0);
    chk("rst_we", 32'(vram_we), 32'd0);
    chk("rst_vaddr", 32'(vram_addr), 32'd0);
    chk("rst_wdata", vram_wdata, 32'd0);
    chk("rst_faddr", 32'(font_addr), 32'd0);
    chk("rst_pix", 32'(pix_on), 32'd0);
    chk("rst_fg", 32'(fg_idx), 32'd0);
    chk("rst_bg", 32'(bg_idx), 32'd0);
    x = 759;
    y = 524;
    advance();
    sample();
    rst_q = 0;
    advance();
    run_to(0, 0);
    p16 = 16'hE718;
    for (int i = 0; i < 16; i++) begin
      sample();
      chk("inv_pix", 32'(pix_on), 32'(p16[15 - i]));
      advance();
    end

    // Continuous host requests for a full line, then random traffic
    auto_host = 1;
    hold_pct = 100;
    start_pct = 100;
    run_to(0, 2);
    hold_pct = 40;
    start_pct = 25;
    run_to(0, 4);

    // Bottom of the visible area into vertical blanking
    sample();
    rst_q = 1;
    advance();
    sample();
    x = 599;
    y = 479;
    advance();
    sample();
    rst_q = 0;
    advance();
    run_to(100, 481);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
